// File: rtl/montred_arbiter.sv
// Round-robin arbiter sharing one montgomery_red engine among NREQ requesters.
// One request in flight: accept, launch pulse, wait for done or watchdog, return a tagged response.
module montred_arbiter #(
    parameter int unsigned NBITS   = 128,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NBITS-1:0]           cfg_m,
    input  logic [$clog2(NBITS)-1:0]   cfg_m_size,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*2*NBITS-1:0]    req_a,
    output logic [NREQ-1:0]            req_ready,
    output logic                       red_enable_p,
    output logic [2*NBITS-1:0]         red_a,
    output logic [NBITS-1:0]           red_m,
    output logic [$clog2(NBITS)-1:0]   red_m_size,
    input  logic [NBITS-1:0]           red_y,
    input  logic                       red_done_p,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [NBITS-1:0]           rsp_y,
    output logic                       rsp_err,
    output logic                       busy
);

    localparam int unsigned AW  = 2 * NBITS;
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [CW-1:0]    cnt;
    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;

    // Requester index k positions after base, wrapping at NREQ.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int unsigned k);
        return IDW'((32'(base) + k) % NREQ);
    endfunction

    // First valid requester at or after ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!gnt_found && req_valid[rr_idx(ptr, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_idx(ptr, k);
            end
        end
    end

    // Accept strobe is combinational so the handshake completes in the IDLE cycle.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            ptr          <= '0;
            cnt          <= '0;
            red_enable_p <= 1'b0;
            red_a        <= '0;
            red_m        <= '0;
            red_m_size   <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_y        <= '0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            red_enable_p <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (gnt_found) begin
                        red_a        <= req_a[32'(gnt_idx) * AW +: AW];
                        red_m        <= cfg_m;
                        red_m_size   <= cfg_m_size;
                        rsp_id       <= gnt_idx;
                        ptr          <= rr_idx(gnt_idx, 1);
                        red_enable_p <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt   <= '0;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    cnt <= cnt + CW'(1);
                    // A done pulse on the watchdog cycle still counts as success.
                    if (red_done_p) begin
                        rsp_y     <= red_y;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rsp_y     <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_montred_arbiter.sv
// Scoreboard bench for montred_arbiter: grant/launch model pushes expected responses,
// a separate response monitor pops and compares; engine is a behavioural stand-in.
module tb_montred_arbiter;

    localparam int NB  = 16;
    localparam int NR  = 4;
    localparam int TO  = 16;
    localparam int AW  = 2 * NB;
    localparam int MSW = $clog2(NB);
    localparam int IDW = $clog2(NR);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NB-1:0]     cfg_m;
    logic [MSW-1:0]    cfg_m_size;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_a;
    logic [NR-1:0]     req_ready;
    logic              red_enable_p;
    logic [AW-1:0]     red_a;
    logic [NB-1:0]     red_m;
    logic [MSW-1:0]    red_m_size;
    logic [NB-1:0]     red_y;
    logic              red_done_p;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [NB-1:0]     rsp_y;
    logic              rsp_err;
    logic              busy;

    montred_arbiter #(.NBITS(NB), .NREQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_m(cfg_m), .cfg_m_size(cfg_m_size),
        .req_valid(req_valid), .req_a(req_a), .req_ready(req_ready),
        .red_enable_p(red_enable_p), .red_a(red_a), .red_m(red_m), .red_m_size(red_m_size),
        .red_y(red_y), .red_done_p(red_done_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [NB-1:0] y;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   eng_lat = 0;
    bit   drv_to = 0;
    bit   drv_to_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Engine stand-in: result is a mod m after eng_lat cycles (0 = never answers).
    int            eng_cnt = 0;
    logic          eng_done = 1'b0;
    logic          stray_done = 1'b0;
    logic [AW-1:0] eng_a;
    logic [NB-1:0] eng_m;
    assign red_done_p = eng_done | stray_done;

    always @(posedge clk) begin
        if (!rst_n) begin
            eng_cnt  = 0;
            eng_done = 1'b0;
            red_y    = '0;
        end else begin
            if (red_enable_p) begin
                eng_cnt = eng_lat;
                eng_a   = red_a;
                eng_m   = red_m;
            end
            #1;
            eng_done = 1'b0;
            red_y    = NB'($urandom);
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done = 1'b1;
                    red_y    = NB'(eng_a % eng_m);
                end
            end
        end
    end

    // Reference model: round-robin pick, launch timing, and expected response.
    int            m_ptr = 0;
    bit            m_busy = 0;
    int            launch_cyc = -1;
    int            a_g;
    logic [NR-1:0] a_exp;
    logic [AW-1:0] l_a;
    logic [NB-1:0] l_m;
    logic [MSW-1:0] l_ms;
    exp_t          a_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ptr      = 0;
            m_busy     = 0;
            launch_cyc = -1;
        end else begin
            a_g = -1;
            if (!m_busy) begin
                for (int k = 0; k < NR; k++) begin
                    if (a_g < 0 && req_valid[(m_ptr + k) % NR]) a_g = (m_ptr + k) % NR;
                end
            end
            a_exp = '0;
            if (a_g >= 0) a_exp[a_g] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(a_exp));
            check("red_enable_p", 64'(red_enable_p), 64'(cyc == launch_cyc));
            if (cyc == launch_cyc) begin
                check("red_a", 64'(red_a), 64'(l_a));
                check("red_m", 64'(red_m), 64'(l_m));
                check("red_m_size", 64'(red_m_size), 64'(l_ms));
            end
            if (a_g >= 0) begin
                l_a        = req_a[a_g * AW +: AW];
                l_m        = cfg_m;
                l_ms       = cfg_m_size;
                launch_cyc = cyc + 1;
                a_e.id     = a_g;
                a_e.err    = (eng_lat < 1 || eng_lat > TO);
                a_e.y      = a_e.err ? '0 : NB'(l_a % l_m);
                a_e.cyc    = launch_cyc + (a_e.err ? TO : eng_lat) + 1;
                sb.push_back(a_e);
                m_busy = 1;
                m_ptr  = (a_g + 1) % NR;
            end
            if (rsp_valid && rsp_ready) m_busy = 0;
            if (drv_to && !drv_to_seen) begin
                drv_to_seen = 1;
                check("drain_timeout", 64'(1), 64'(0));
            end
        end
    end

    // Response monitor.
    exp_t b_e;
    bit   prev_v = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_v = 0;
            check("reset_ctl", 64'({rsp_valid, red_enable_p, busy, rsp_err, req_ready}), 64'(0));
            check("reset_data", 64'({rsp_y, rsp_id, red_m, red_m_size}), 64'(0));
            check("reset_red_a", 64'(red_a), 64'(0));
        end else begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_rsp", 64'(1), 64'(0));
                end else begin
                    b_e = sb[0];
                    if (!prev_v) check("rsp_cycle", 64'(cyc), 64'(b_e.cyc));
                    check("rsp_id", 64'(rsp_id), 64'(b_e.id));
                    check("rsp_y", 64'(rsp_y), 64'(b_e.y));
                    check("rsp_err", 64'(rsp_err), 64'(b_e.err));
                    check("busy_in_rsp", 64'(busy), 64'(1));
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
            prev_v = rsp_valid && !rsp_ready;
        end
    end

    // Present mask, retire each requester on its grant, drain all responses.
    task automatic serve(input logic [NR-1:0] mask, input int lat, input int bp,
                         input bit stray_launch, input bit allow_drop);
        logic [NR-1:0] pending;
        logic [NR-1:0] rr;
        int  ngnt, nrsp, hold;
        bit  hs, done;
        eng_lat = lat;
        pending = mask;
        ngnt = 0; nrsp = 0; hold = 0; done = 0;
        for (int i = 0; i < NR; i++) req_a[i * AW +: AW] = AW'($urandom);
        req_valid = pending;
        rsp_ready = (bp == 0);
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge clk);
            rr = req_ready;
            hs = rsp_valid && rsp_ready;
            if (rsp_valid && !rsp_ready) hold++;
            @(posedge clk);
            #1;
            if (rr != 0) begin
                ngnt++;
                for (int i = 0; i < NR; i++) if (rr[i]) req_a[i * AW +: AW] = AW'($urandom);
            end
            if (hs) begin
                nrsp++;
                hold = 0;
            end
            pending &= ~rr;
            if (allow_drop && pending != 0 && $urandom_range(0, 15) == 0)
                pending &= ~(NR'(1) << $urandom_range(0, NR - 1));
            req_valid  = pending;
            rsp_ready  = (bp == 0) || (hold >= bp);
            stray_done = stray_launch && (rr != 0);
            done       = (pending == 0) && (nrsp == ngnt);
        end
        stray_done = 1'b0;
        if (!done) drv_to = 1;
    endtask

    initial begin
        bit got;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        rsp_ready  = 1'b1;
        cfg_m      = 16'hC007;
        cfg_m_size = 4'd15;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        serve(4'b0001, 3, 0, 0, 0);     // single request
        serve(4'b1111, 2, 0, 0, 0);     // round robin
        serve(4'b0011, 4, 10, 0, 0);    // response backpressure
        serve(4'b0001, 0, 0, 0, 0);     // watchdog abort
        serve(4'b1000, TO, 0, 0, 0);    // done on the watchdog cycle
        serve(4'b0100, 0, 0, 1, 0);     // done during LAUNCH is ignored

        // Stray done while idle.
        @(posedge clk);
        #1 stray_done = 1'b1;
        @(posedge clk);
        #1 stray_done = 1'b0;
        repeat (4) @(posedge clk);

        // Reset in the middle of BUSY.
        #1;
        eng_lat   = 0;
        req_valid = 4'b0001;
        got = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            got = req_ready[0];
        end
        if (!got) drv_to = 1;
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        serve(4'b0100, 2, 0, 0, 0);

        for (int t = 0; t < 25; t++) begin
            cfg_m      = NB'($urandom) | NB'(1) | (NB'(1) << (NB - 1));
            cfg_m_size = MSW'($urandom);
            serve(NR'($urandom_range(1, (1 << NR) - 1)), int'($urandom_range(0, 20)),
                  int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, 1);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
